pdm_cic_decim: RTL and testbench
================================

Name: pdm_cic_decim

Overview:
- Downstream stage of the FMCW sonar front end: takes the 2-channel 1-bit PDM microphone stream, latched once per MIC_CK period, and decimates it to 16-bit signed PCM.
- Both channels pass through a 3rd-order CIC decimator (integrate at the strobe rate, comb at the decimated rate) with rounding-free scaling and saturation.
- The PCM output feeds the later dechirp/beat-frequency processing. The block sits beside the chirp generator in the 48 MHz CK_i domain.

Parameters:
- C_LOG2R, 6, log2 of the decimation ratio R (R=64, so 4 MHz in gives 62.5 kS/s out); legal range 3..8.
- C_SKIP, 3, number of initial decimated outputs suppressed after reset or enable to cover the CIC transient; 0 disables suppression.

Ports:
- CK_i  in  1  system clock, 48 MHz.
- RST_i  in  1  reset, synchronous, active-high.
- EN_i  in  1  enable; low acts as a synchronous clear.
- DAT_EE_i  in  1  one-cycle strobe marking a valid PDM bit pair.
- MICs_DAT_i  in  2  PDM bits, one per channel; [0]=ch0, [1]=ch1.
- PCMs_o  out  32  {ch1[15:0], ch0[15:0]}, two's complement.
- PCM_EE_o  out  1  one-cycle strobe, PCMs_o updated.

Behaviour:
- Constants: N=3, R=2^C_LOG2R, W=N*C_LOG2R+2 (20 at the default), S=N*C_LOG2R-15 (3 at the default). When S<0, shift left by -S.
- Input map per channel: bit 1 gives +1, bit 0 gives -1, sign-extended to W.
- Integrators I1..I3 per channel are W-bit. They update only on cycles with DAT_EE_i=1 and EN_i=1: I1+=x, I2+=I1_new, I3+=I2_new. All three settle in one cycle (chained adders).
- Integrator arithmetic wraps modulo 2^W. It never saturates; wrap is required for CIC correctness.
- Phase counter: C_LOG2R bits, increments on each accepted strobe and wraps R-1 to 0. The strobe that wraps it is the frame strobe.
- Comb stage, one cycle after the frame strobe: three combs run on the new I3 value, y = c3 using differential delays of 1 decimated sample, W-bit wrap arithmetic. The comb delay registers update at the same time.
- Output stage, two cycles after the frame strobe: PCMs_o = sat16(y >>> S), clamped to [-32768, +32767]. Full-scale +R^N therefore reads 32767 and -R^N reads -32768.
- PCM_EE_o pulses for 1 cycle at that same point. Latency from frame strobe cycle t is fixed: PCM_EE_o high in cycle t+2.
- Skip counter: counts emitted frames up to C_SKIP. While count < C_SKIP the comb and delay registers still update, but PCM_EE_o stays 0 and PCMs_o holds its value.
- Strobe spacing: DAT_EE_i must be ≥3 cycles apart (the system gives 12). Closer spacing is undefined; the bench does not exercise it.
- DAT_EE_i while EN_i=0: ignored.
- Reset, or EN_i=0: the next edge clears integrators, combs, phase, skip count, PCMs_o=0 and PCM_EE_o=0. A pending output in flight is dropped.
- RST_i=1 overrides EN_i.
- Re-enable: accumulation restarts from phase 0, with the skip count applied again.

Decomposition:
- Shared package/include: N, the W and S derivations, and the ±1 input mapping constant.
- One sub-module, cic3_chan: integrators, comb delays, scaler and saturator for a single channel. It is instantiated twice.
- Phase, skip and strobe pipeline logic live in the top module and are shared by both channels.

Test Plan:
- Constant 1s on both channels, defaults: the first 3 frames emit nothing; from frame 4 on, PCMs_o=0x7FFF_7FFF, with PCM_EE_o exactly 2 cycles after every 64th strobe.
- Constant 0s on both channels: steady PCMs_o=0x8000_8000.
- Alternating 1,0 on ch0 with constant 1 on ch1: ch0 settles to 0x0000 and ch1 to 0x7FFF.
- Repeating 1,1,1,0 on ch0 (density 0.75): ch0 settles to y=2^17, so PCM ch0=0x4000 (16384). The bench checks that integrator wrap occurs without output error.
- RST_i pulsed for 1 cycle at strobe 30 of a frame: all outputs are 0 on the next edge; the next PCM_EE_o comes after (3+1)*64 strobes.
- EN_i low for 500 cycles with strobes running: no PCM_EE_o. On re-enable the sequence matches the post-reset case, and C_SKIP=0 builds emit from frame 1.

Source files
------------

// File: rtl/pdm_cic_decim_pkg.sv
// Shared constants for the PDM-to-PCM CIC decimator: filter order, width and
// scaling derivations, and the +/-1 mapping applied to each PDM bit.
package pdm_cic_decim_pkg;

  localparam int unsigned CIC_N = 3;
  localparam int unsigned PCM_W = 16;

  localparam logic signed [1:0] PDM_ONE  = 2'sb01;
  localparam logic signed [1:0] PDM_ZERO = 2'sb11;

  // Register growth is N*log2(R) bits on top of the 2-bit signed input.
  function automatic int unsigned cic_width(input int unsigned log2r);
    return CIC_N * log2r + 2;
  endfunction

  // Positive result means shift right; negative means shift left.
  function automatic int cic_shift(input int unsigned log2r);
    return int'(CIC_N * log2r) - 15;
  endfunction

endpackage

// File: rtl/pdm_cic_decim_cic3_chan.sv
// One channel of the third-order CIC: chained integrators at the PDM rate,
// three combs at the frame rate, then scaling and 16-bit saturation.
module cic3_chan
  import pdm_cic_decim_pkg::*;
#(
  parameter int unsigned W     = 20,
  parameter int          SHIFT = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          acc_en,
  input  logic          comb_en,
  input  logic          load_en,
  input  logic          dat,
  output logic [15:0]   pcm_o
);

  localparam int unsigned SHR = (SHIFT >= 0) ? int'(SHIFT) : 0;
  localparam int unsigned SHL = (SHIFT < 0) ? int'(-SHIFT) : 0;

  logic [W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [15:0]  pcm_q, pcm_d;

  logic [W-1:0]       x;
  logic [W-1:0]       c1, c2, c3;
  logic signed [31:0] y_ext;
  logic signed [31:0] scaled;
  logic [15:0]        sat;

  always_comb begin
    x = dat ? {{(W-2){PDM_ONE[1]}}, PDM_ONE} : {{(W-2){PDM_ZERO[1]}}, PDM_ZERO};

    // Integrators wrap modulo 2^W; the combs undo the wrap exactly.
    i1_d = i1_q;
    i2_d = i2_q;
    i3_d = i3_q;
    if (acc_en) begin
      i1_d = i1_q + x;
      i2_d = i2_q + i1_d;
      i3_d = i3_q + i2_d;
    end

    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;

    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    if (comb_en) begin
      d1_d = i3_q;
      d2_d = c1;
      d3_d = c2;
    end

    y_ext  = {{(32-W){c3[W-1]}}, c3};
    scaled = (y_ext >>> SHR) <<< SHL;
    if (scaled > 32'sd32767) begin
      sat = 16'h7FFF;
    end else if (scaled < -32'sd32768) begin
      sat = 16'h8000;
    end else begin
      sat = scaled[15:0];
    end

    pcm_d = load_en ? sat : pcm_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      i1_q  <= '0;
      i2_q  <= '0;
      i3_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
      d3_q  <= '0;
      pcm_q <= '0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      i3_q  <= i3_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      d3_q  <= d3_d;
      pcm_q <= pcm_d;
    end
  end

  assign pcm_o = pcm_q;

endmodule

// File: rtl/pdm_cic_decim.sv
// Two-channel PDM to 16-bit PCM decimator. Phase, transient-skip and the
// frame-strobe pipeline are shared; each channel runs its own CIC datapath.
module pdm_cic_decim
  import pdm_cic_decim_pkg::*;
#(
  parameter int unsigned C_LOG2R = 6,
  parameter int unsigned C_SKIP  = 3
) (
  input  logic        CK_i,
  input  logic        RST_i,
  input  logic        EN_i,
  input  logic        DAT_EE_i,
  input  logic [1:0]  MICs_DAT_i,
  output logic [31:0] PCMs_o,
  output logic        PCM_EE_o
);

  localparam int unsigned W     = cic_width(C_LOG2R);
  localparam int          SHIFT = cic_shift(C_LOG2R);
  localparam int unsigned SKW   = (C_SKIP < 2) ? 1 : $clog2(C_SKIP + 1);

  logic [C_LOG2R-1:0] phase_q, phase_d;
  logic [SKW-1:0]     skip_q, skip_d;
  logic               comb_go_q, comb_go_d;
  logic               pcm_ee_q, pcm_ee_d;

  logic clr, accept, frame, skip_done, emit;

  always_comb begin
    clr       = RST_i | ~EN_i;
    accept    = DAT_EE_i & EN_i;
    frame     = accept && (phase_q == '1);
    phase_d   = accept ? phase_q + 1'b1 : phase_q;
    comb_go_d = frame;

    // Combs still run on skipped frames so their delay lines fill up.
    skip_done = (skip_q == SKW'(C_SKIP));
    emit      = comb_go_q & skip_done;
    skip_d    = (comb_go_q && !skip_done) ? skip_q + 1'b1 : skip_q;
    pcm_ee_d  = emit;
  end

  always_ff @(posedge CK_i) begin
    if (clr) begin
      phase_q   <= '0;
      skip_q    <= '0;
      comb_go_q <= 1'b0;
      pcm_ee_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      skip_q    <= skip_d;
      comb_go_q <= comb_go_d;
      pcm_ee_q  <= pcm_ee_d;
    end
  end

  cic3_chan #(.W(W), .SHIFT(SHIFT)) u_ch0 (
    .clk     (CK_i),
    .clr     (clr),
    .acc_en  (accept),
    .comb_en (comb_go_q),
    .load_en (emit),
    .dat     (MICs_DAT_i[0]),
    .pcm_o   (PCMs_o[15:0])
  );

  cic3_chan #(.W(W), .SHIFT(SHIFT)) u_ch1 (
    .clk     (CK_i),
    .clr     (clr),
    .acc_en  (accept),
    .comb_en (comb_go_q),
    .load_en (emit),
    .dat     (MICs_DAT_i[1]),
    .pcm_o   (PCMs_o[31:16])
  );

  assign PCM_EE_o = pcm_ee_q;

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Directed bench for pdm_cic_decim: default build plus a C_SKIP=0 build fed
// the same stimulus; expected PCM words are hand-derived CIC steady states.
`timescale 1ns/1ps
module tb_pdm_cic_decim;

  logic        CK_i = 1'b0;
  logic        RST_i = 1'b1;
  logic        EN_i = 1'b1;
  logic        DAT_EE_i = 1'b0;
  logic [1:0]  MICs_DAT_i = 2'b00;
  logic [31:0] PCMs_o, PCMs0_o;
  logic        PCM_EE_o, PCM_EE0_o;

  int checks = 0;
  int failures = 0;

  int sidx;
  int stray, stray0;
  int first_frame, first_frame0;
  logic [31:0] emits[$];
  logic [31:0] emits0[$];

  always #5 CK_i = ~CK_i;

  pdm_cic_decim #(.C_LOG2R(6), .C_SKIP(3)) u_dut (
    .CK_i       (CK_i),
    .RST_i      (RST_i),
    .EN_i       (EN_i),
    .DAT_EE_i   (DAT_EE_i),
    .MICs_DAT_i (MICs_DAT_i),
    .PCMs_o     (PCMs_o),
    .PCM_EE_o   (PCM_EE_o)
  );

  pdm_cic_decim #(.C_LOG2R(6), .C_SKIP(0)) u_dut_noskip (
    .CK_i       (CK_i),
    .RST_i      (RST_i),
    .EN_i       (EN_i),
    .DAT_EE_i   (DAT_EE_i),
    .MICs_DAT_i (MICs_DAT_i),
    .PCMs_o     (PCMs0_o),
    .PCM_EE_o   (PCM_EE0_o)
  );

  // Pattern modes: 0 all zeros, 1 all ones, 2 alternating 1,0, 3 repeating 1,1,1,0.
  function automatic logic pat_bit(input int m, input int k);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2 == 0);
      default: return (k % 4 != 3);
    endcase
  endfunction

  task automatic clear_obs();
    sidx = 0;
    stray = 0;
    stray0 = 0;
    first_frame = -1;
    first_frame0 = -1;
    emits.delete();
    emits0.delete();
  endtask

  task automatic do_reset();
    @(posedge CK_i); #1 RST_i = 1'b1;
    @(posedge CK_i); #1 RST_i = 1'b0;
    clear_obs();
  endtask

  // Strobes 4 cycles apart; PCM_EE is sampled in the three cycles after each
  // strobe and only the second one may carry a frame output.
  task automatic run_strobes(input int n, input int m0, input int m1);
    logic ee1, ee2, ee3, ef1, ef2, ef3;
    for (int i = 0; i < n; i++) begin
      @(posedge CK_i); #1;
      MICs_DAT_i = {pat_bit(m1, sidx), pat_bit(m0, sidx)};
      DAT_EE_i = 1'b1;
      sidx++;
      @(posedge CK_i); #1;
      DAT_EE_i = 1'b0;
      ee1 = PCM_EE_o; ef1 = PCM_EE0_o;
      @(posedge CK_i); #1;
      ee2 = PCM_EE_o; ef2 = PCM_EE0_o;
      if (ee2) begin
        if (sidx % 64 == 0) begin
          emits.push_back(PCMs_o);
          if (first_frame < 0) first_frame = sidx / 64;
        end else stray++;
      end
      if (ef2) begin
        if (sidx % 64 == 0) begin
          emits0.push_back(PCMs0_o);
          if (first_frame0 < 0) first_frame0 = sidx / 64;
        end else stray0++;
      end
      @(posedge CK_i); #1;
      ee3 = PCM_EE_o; ef3 = PCM_EE0_o;
      if (ee1 || ee3) stray++;
      if (ef1 || ef3) stray0++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CK_i);
    #1;
    checks++;
    if (PCMs_o !== 32'h0) begin
      failures++; $display("FAIL reset_pcm: got %h expected 00000000", PCMs_o);
    end
    checks++;
    if (PCM_EE_o !== 1'b0) begin
      failures++; $display("FAIL reset_ee: got %b expected 0", PCM_EE_o);
    end
    RST_i = 1'b0;
    clear_obs();
  endtask

  task automatic test_const_ones();
    do_reset();
    run_strobes(192, 1, 1);
    checks++;
    if (emits.size() != 0) begin
      failures++; $display("FAIL ones_skip_emits: got %0d expected 0", emits.size());
    end
    checks++;
    if (PCMs_o !== 32'h0) begin
      failures++; $display("FAIL ones_skip_hold: got %h expected 00000000", PCMs_o);
    end
    run_strobes(192, 1, 1);
    checks++;
    if (emits.size() != 3) begin
      failures++; $display("FAIL ones_emit_count: got %0d expected 3", emits.size());
    end
    checks++;
    if (first_frame != 4) begin
      failures++; $display("FAIL ones_first_frame: got %0d expected 4", first_frame);
    end
    foreach (emits[i]) begin
      checks++;
      if (emits[i] !== 32'h7FFF_7FFF) begin
        failures++; $display("FAIL ones_value[%0d]: got %h expected 7fff7fff", i, emits[i]);
      end
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL ones_timing: got %0d stray pulses expected 0", stray);
    end
    checks++;
    if (first_frame0 != 1 || emits0.size() != 6) begin
      failures++;
      $display("FAIL noskip_emits: got first=%0d count=%0d expected first=1 count=6",
               first_frame0, emits0.size());
    end
    for (int i = 3; i < emits0.size(); i++) begin
      checks++;
      if (emits0[i] !== 32'h7FFF_7FFF) begin
        failures++; $display("FAIL noskip_value[%0d]: got %h expected 7fff7fff", i, emits0[i]);
      end
    end
    checks++;
    if (stray0 != 0) begin
      failures++; $display("FAIL noskip_timing: got %0d stray pulses expected 0", stray0);
    end
  endtask

  task automatic test_const_zeros();
    do_reset();
    run_strobes(384, 0, 0);
    checks++;
    if (emits.size() != 3) begin
      failures++; $display("FAIL zeros_emit_count: got %0d expected 3", emits.size());
    end
    foreach (emits[i]) begin
      checks++;
      if (emits[i] !== 32'h8000_8000) begin
        failures++; $display("FAIL zeros_value[%0d]: got %h expected 80008000", i, emits[i]);
      end
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL zeros_timing: got %0d stray pulses expected 0", stray);
    end
  endtask

  task automatic test_alternating();
    do_reset();
    run_strobes(384, 2, 1);
    checks++;
    if (emits.size() != 3) begin
      failures++; $display("FAIL alt_emit_count: got %0d expected 3", emits.size());
    end
    foreach (emits[i]) begin
      checks++;
      if (emits[i] !== 32'h7FFF_0000) begin
        failures++; $display("FAIL alt_value[%0d]: got %h expected 7fff0000", i, emits[i]);
      end
    end
  endtask

  // Eight frames push I3 far past 2^19, so correct outputs imply clean wrap.
  task automatic test_density_wrap();
    do_reset();
    run_strobes(512, 3, 1);
    checks++;
    if (emits.size() != 5) begin
      failures++; $display("FAIL dens_emit_count: got %0d expected 5", emits.size());
    end
    foreach (emits[i]) begin
      checks++;
      if (emits[i] !== 32'h7FFF_4000) begin
        failures++; $display("FAIL dens_value[%0d]: got %h expected 7fff4000", i, emits[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    run_strobes(256 + 30, 1, 1);
    checks++;
    if (emits.size() != 1) begin
      failures++; $display("FAIL rstmid_pre_count: got %0d expected 1", emits.size());
    end
    @(posedge CK_i); #1 RST_i = 1'b1;
    @(posedge CK_i); #1 RST_i = 1'b0;
    checks++;
    if (PCMs_o !== 32'h0 || PCM_EE_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_clear: got pcm=%h ee=%b expected 00000000 0", PCMs_o, PCM_EE_o);
    end
    clear_obs();
    run_strobes(255, 1, 1);
    checks++;
    if (emits.size() != 0) begin
      failures++; $display("FAIL rstmid_early: got %0d emits expected 0", emits.size());
    end
    run_strobes(1, 1, 1);
    checks++;
    if (emits.size() != 1 || first_frame != 4) begin
      failures++; $display("FAIL rstmid_restart: got count=%0d first=%0d expected 1 4", emits.size(), first_frame);
    end
  endtask

  task automatic test_enable();
    int ee_cnt;
    do_reset();
    run_strobes(319, 1, 1);
    checks++;
    if (emits.size() != 1) begin
      failures++; $display("FAIL en_pre_count: got %0d expected 1", emits.size());
    end
    // Frame strobe for frame 5, then drop EN while its output is in flight.
    @(posedge CK_i); #1;
    MICs_DAT_i = 2'b11;
    DAT_EE_i = 1'b1;
    @(posedge CK_i); #1;
    DAT_EE_i = 1'b0;
    EN_i = 1'b0;
    @(posedge CK_i); #1;
    checks++;
    if (PCM_EE_o !== 1'b0 || PCMs_o !== 32'h0) begin
      failures++; $display("FAIL en_drop_inflight: got ee=%b pcm=%h expected 0 00000000", PCM_EE_o, PCMs_o);
    end
    ee_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge CK_i); #1;
      DAT_EE_i = (i % 4 == 0);
      if (PCM_EE_o) ee_cnt++;
    end
    DAT_EE_i = 1'b0;
    checks++;
    if (ee_cnt != 0) begin
      failures++; $display("FAIL en_low_pulses: got %0d expected 0", ee_cnt);
    end
    @(posedge CK_i); #1 EN_i = 1'b1;
    clear_obs();
    run_strobes(256, 1, 1);
    checks++;
    if (emits.size() != 1 || first_frame != 4) begin
      failures++; $display("FAIL en_restart: got count=%0d first=%0d expected 1 4", emits.size(), first_frame);
    end
    checks++;
    if (emits.size() != 0 && emits[0] !== 32'h7FFF_7FFF) begin
      failures++; $display("FAIL en_restart_value: got %h expected 7fff7fff", emits[0]);
    end
    checks++;
    if (first_frame0 != 1 || stray != 0) begin
      failures++; $display("FAIL en_noskip_first: got first=%0d stray=%0d expected 1 0", first_frame0, stray);
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_const_ones();
    test_const_zeros();
    test_alternating();
    test_density_wrap();
    test_reset_midframe();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
